// File: rtl/branch_target_predictor_if.sv
// Fetch-side lookup and execute-side training bundle for the branch target predictor.
// The master drives the PCs and training data; the slave is the predictor.
interface branch_target_predictor_if #(
  parameter int COUNT_W = 32
);
  logic [31:0]        lookup_pc;
  logic               hit;
  logic               pred_taken;
  logic [29:0]        pred_target;
  logic               flush;
  logic               upd_en;
  logic [31:0]        upd_pc;
  logic               upd_taken;
  logic [29:0]        upd_target;
  logic               upd_pred_taken;
  logic [COUNT_W-1:0] upd_count;
  logic [COUNT_W-1:0] mispredict_count;

  modport master (
    output lookup_pc, flush, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken,
    input  hit, pred_taken, pred_target, upd_count, mispredict_count
  );
  modport slave (
    input  lookup_pc, flush, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken,
    output hit, pred_taken, pred_target, upd_count, mispredict_count
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Set-associative BTB with saturating direction counters, per-set LRU, flush and perf counters.
// One btb_way instance per way; the top arbitrates allocation and owns LRU state.
module btb_way #(
  parameter int INDEX_W = 2,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 28
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               rd_match,
  output logic               rd_taken,
  output logic [29:0]        rd_target,
  input  logic [INDEX_W-1:0] up_idx,
  input  logic [TAG_W-1:0]   up_tag,
  output logic               up_match,
  output logic               up_valid,
  input  logic               flush,
  input  logic               alloc,
  input  logic               train,
  input  logic               taken,
  input  logic [29:0]        target
);
  localparam int SETS = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] WEAK = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] MAX  = '1;

  logic [SETS-1:0]             valid;
  logic [SETS-1:0][TAG_W-1:0]  tags;
  logic [SETS-1:0][29:0]       targets;
  logic [SETS-1:0][CTR_W-1:0]  ctrs;

  assign rd_match  = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rd_taken  = ctrs[rd_idx][CTR_W-1];
  assign rd_target = targets[rd_idx];
  assign up_valid  = valid[up_idx];
  assign up_match  = valid[up_idx] && (tags[up_idx] == up_tag);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid   <= '0;
      tags    <= '0;
      targets <= '0;
      ctrs    <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (alloc) begin
      valid[up_idx]   <= 1'b1;
      tags[up_idx]    <= up_tag;
      targets[up_idx] <= target;
      ctrs[up_idx]    <= WEAK;
    end else if (train) begin
      // Not-taken leaves the stored target alone; it still describes the taken path.
      if (taken) begin
        targets[up_idx] <= target;
        if (ctrs[up_idx] != MAX) ctrs[up_idx] <= ctrs[up_idx] + 1'b1;
      end else if (ctrs[up_idx] != '0) begin
        ctrs[up_idx] <= ctrs[up_idx] - 1'b1;
      end
    end
  end
endmodule

module branch_target_predictor #(
  parameter int INDEX_W = 2,
  parameter int WAYS    = 2,
  parameter int CTR_W   = 2,
  parameter int COUNT_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  branch_target_predictor_if.slave bus
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  logic [INDEX_W-1:0] ridx, uidx;
  logic [TAG_W-1:0]   rtag, utag;
  logic [WAYS-1:0]    rmatch, rtaken, umatch, uvalid, alloc_oh, train_oh;
  logic [WAYS-1:0][29:0] rtarget;
  logic               victim, do_upd, do_alloc;
  logic [COUNT_W-1:0] cnt_upd, cnt_mis;
  logic               unused_pc_lsbs;

  assign ridx = bus.lookup_pc[INDEX_W+1:2];
  assign rtag = bus.lookup_pc[31:INDEX_W+2];
  assign uidx = bus.upd_pc[INDEX_W+1:2];
  assign utag = bus.upd_pc[31:INDEX_W+2];
  assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  assign do_upd   = bus.upd_en && !bus.flush;
  assign do_alloc = do_upd && bus.upd_taken && !(|umatch);
  assign train_oh = do_upd ? umatch : '0;

  always_comb begin
    alloc_oh = '0;
    for (int w = 0; w < WAYS; w++) alloc_oh[w] = do_alloc && (int'(victim) == w);
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    btb_way #(.INDEX_W(INDEX_W), .CTR_W(CTR_W), .TAG_W(TAG_W)) u_way (
      .CLK(CLK), .nRST(nRST),
      .rd_idx(ridx), .rd_tag(rtag),
      .rd_match(rmatch[w]), .rd_taken(rtaken[w]), .rd_target(rtarget[w]),
      .up_idx(uidx), .up_tag(utag),
      .up_match(umatch[w]), .up_valid(uvalid[w]),
      .flush(bus.flush), .alloc(alloc_oh[w]), .train(train_oh[w]),
      .taken(bus.upd_taken), .target(bus.upd_target)
    );
  end

  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru;
    assign victim = !uvalid[0] ? 1'b0 : (!uvalid[1] ? 1'b1 : lru[uidx]);
    // LRU names the way to evict next, so it points away from whichever way was touched.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)              lru <= '0;
      else if (bus.flush)     lru <= '0;
      else if (|train_oh)     lru[uidx] <= umatch[0];
      else if (do_alloc)      lru[uidx] <= ~victim;
    end
  end else begin : g_nolru
    assign victim = 1'b0;
  end

  always_comb begin
    bus.hit         = 1'b0;
    bus.pred_taken  = 1'b0;
    bus.pred_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rmatch[w]) begin
        bus.hit         = 1'b1;
        bus.pred_taken  = bus.pred_taken | rtaken[w];
        bus.pred_target = bus.pred_target | rtarget[w];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_upd <= '0;
      cnt_mis <= '0;
    end else if (bus.upd_en) begin
      cnt_upd <= cnt_upd + 1'b1;
      if (bus.upd_pred_taken != bus.upd_taken) cnt_mis <= cnt_mis + 1'b1;
    end
  end

  assign bus.upd_count        = cnt_upd;
  assign bus.mispredict_count = cnt_mis;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor (INDEX_W=2, WAYS=2, CTR_W=2, COUNT_W=4).
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  logic [3:0] exp_upd = '0;
  logic [3:0] exp_mis = '0;

  branch_target_predictor_if #(.COUNT_W(4)) bif ();

  branch_target_predictor #(.INDEX_W(2), .WAYS(2), .CTR_W(2), .COUNT_W(4)) dut (
    .CLK(clk), .nRST(nrst), .bus(bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic eh,
                      input logic et, input logic [29:0] etg);
    bif.lookup_pc = pc;
    #1;
    chk({tag, ".hit"}, 32'(bif.hit), 32'(eh));
    chk({tag, ".taken"}, 32'(bif.pred_taken), 32'(et));
    chk({tag, ".target"}, 32'(bif.pred_target), 32'(etg));
  endtask

  task automatic cnts(input string tag);
    chk({tag, ".upd_count"}, 32'(bif.upd_count), 32'(exp_upd));
    chk({tag, ".mis_count"}, 32'(bif.mispredict_count), 32'(exp_mis));
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [29:0] tg, input logic pt);
    @(negedge clk);
    bif.upd_en = 1'b1; bif.upd_pc = pc; bif.upd_taken = tk;
    bif.upd_target = tg; bif.upd_pred_taken = pt;
    @(posedge clk);
    exp_upd++;
    if (pt != tk) exp_mis++;
    #1;
    bif.upd_en = 1'b0;
  endtask

  initial begin
    bif.lookup_pc = '0; bif.flush = 1'b0; bif.upd_en = 1'b0; bif.upd_pc = '0;
    bif.upd_taken = 1'b0; bif.upd_target = '0; bif.upd_pred_taken = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); nrst = 1'b1;

    // Populate, then assert reset mid-cycle while an update is pending.
    upd(32'h40, 1'b1, 30'h40, 1'b0);
    look("pre_reset", 32'h40, 1'b1, 1'b1, 30'h40);
    @(negedge clk);
    bif.upd_en = 1'b1; bif.upd_pc = 32'h80; bif.upd_taken = 1'b1; bif.upd_pred_taken = 1'b0;
    #2; nrst = 1'b0;
    exp_upd = '0; exp_mis = '0;
    look("reset", 32'h40, 1'b0, 1'b0, 30'h0);
    cnts("reset");
    bif.upd_en = 1'b0;
    @(negedge clk); nrst = 1'b1;

    // Allocate and hit
    upd(32'h40, 1'b1, 30'h40, 1'b0);
    look("alloc", 32'h40, 1'b1, 1'b1, 30'h40);
    cnts("alloc");

    // Saturation down: ctr 1,0,0; target untouched by not-taken
    upd(32'h40, 1'b0, 30'h99, 1'b1); look("nt1", 32'h40, 1'b1, 1'b0, 30'h40);
    upd(32'h40, 1'b0, 30'h99, 1'b0); look("nt2", 32'h40, 1'b1, 1'b0, 30'h40);
    upd(32'h40, 1'b0, 30'h99, 1'b0); look("nt3", 32'h40, 1'b1, 1'b0, 30'h40);
    // Saturation up: ctr 1,2,3,3; last taken overwrites target
    upd(32'h40, 1'b1, 30'h40, 1'b0); look("t1", 32'h40, 1'b1, 1'b0, 30'h40);
    upd(32'h40, 1'b1, 30'h40, 1'b0); look("t2", 32'h40, 1'b1, 1'b1, 30'h40);
    upd(32'h40, 1'b1, 30'h40, 1'b1); look("t3", 32'h40, 1'b1, 1'b1, 30'h40);
    upd(32'h40, 1'b1, 30'h48, 1'b1); look("t4", 32'h40, 1'b1, 1'b1, 30'h48);
    // One not-taken from saturated 3 gives 2: still predicted taken
    upd(32'h40, 1'b0, 30'h11, 1'b1); look("sat_hi", 32'h40, 1'b1, 1'b1, 30'h48);
    cnts("sat");

    // LRU eviction in set 0
    upd(32'h40, 1'b1, 30'h48, 1'b1);
    upd(32'h80, 1'b1, 30'h20, 1'b0);
    look("lru_80_in", 32'h80, 1'b1, 1'b1, 30'h20);
    upd(32'h40, 1'b1, 30'h48, 1'b1);
    upd(32'hC0, 1'b1, 30'h30, 1'b0);
    look("lru_80_out", 32'h80, 1'b0, 1'b0, 30'h0);
    look("lru_40", 32'h40, 1'b1, 1'b1, 30'h48);
    look("lru_c0", 32'hC0, 1'b1, 1'b1, 30'h30);
    upd(32'h100, 1'b0, 30'h5, 1'b0);
    look("nt_miss", 32'h100, 1'b0, 1'b0, 30'h0);
    look("nt_miss_40", 32'h40, 1'b1, 1'b1, 30'h48);
    look("nt_miss_c0", 32'hC0, 1'b1, 1'b1, 30'h30);

    // Same-cycle update and lookup: old value until the edge
    @(negedge clk);
    bif.upd_en = 1'b1; bif.upd_pc = 32'hC0; bif.upd_taken = 1'b1;
    bif.upd_target = 30'h3C; bif.upd_pred_taken = 1'b1;
    bif.lookup_pc = 32'hC0;
    #1;
    chk("bypass.old_target", 32'(bif.pred_target), 32'h30);
    @(posedge clk); exp_upd++;
    #1; bif.upd_en = 1'b0;
    look("bypass.new", 32'hC0, 1'b1, 1'b1, 30'h3C);

    // Flush wins over a simultaneous allocating update, which is still counted
    @(negedge clk);
    bif.flush = 1'b1; bif.upd_en = 1'b1; bif.upd_pc = 32'h44; bif.upd_taken = 1'b1;
    bif.upd_target = 30'h7; bif.upd_pred_taken = 1'b0;
    @(posedge clk); exp_upd++; exp_mis++;
    #1; bif.flush = 1'b0; bif.upd_en = 1'b0;
    look("flush_44", 32'h44, 1'b0, 1'b0, 30'h0);
    look("flush_40", 32'h40, 1'b0, 1'b0, 30'h0);
    look("flush_c0", 32'hC0, 1'b0, 1'b0, 30'h0);
    cnts("flush");

    // After flush, allocation fills way 0 then way 1 again
    upd(32'h80, 1'b1, 30'h21, 1'b0);
    upd(32'hC0, 1'b1, 30'h31, 1'b0);
    look("refill_80", 32'h80, 1'b1, 1'b1, 30'h21);
    look("refill_c0", 32'hC0, 1'b1, 1'b1, 30'h31);

    // Counter wrap: 17 updates, 3 mispredicts
    @(negedge clk); nrst = 1'b0; #1; nrst = 1'b1;
    exp_upd = '0; exp_mis = '0;
    for (int i = 0; i < 17; i++) begin
      logic tk;
      tk = 1'(i);
      upd(32'h200 + 32'(i * 4), tk, 30'h1, (i < 3) ? ~tk : tk);
    end
    chk("wrap.upd_count", 32'(bif.upd_count), 32'd1);
    chk("wrap.mis_count", 32'(bif.mispredict_count), 32'd3);
    cnts("wrap_model");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised, set-associative branch target buffer with per-entry saturating direction counters, LRU replacement, bulk flush and performance counters. It is the successor to the direct-mapped, always-taken predictor in the pipelined datapath. The IF stage queries it combinationally with the current PC. The EX stage trains it once the branch resolves.

## Interface
Parameters:
- INDEX_W, 2: set index width; SETS = 2**INDEX_W; index = pc[INDEX_W+1:2].
- WAYS, 2: associativity; legal values are 1 or 2 only.
- CTR_W, 2: direction counter width; legal range is 1..4.
- COUNT_W, 32: performance counter width.

Ports (clock and reset first):
- CLK, in, 1: clock; all state updates on rising edge.
- nRST, in, 1: asynchronous, active-low reset.
- lookup_pc, in, 32: PC being fetched.
- hit, out, 1: lookup_pc matches a valid entry.
- pred_taken, out, 1: hit & MSB of the matching counter.
- pred_target, out, 30: word target of the matching entry; 0 on miss.
- flush, in, 1: invalidate all entries.
- upd_en, in, 1: train with a resolved branch this cycle.
- upd_pc, in, 32: PC of the resolved branch.
- upd_taken, in, 1: actual branch outcome.
- upd_target, in, 30: actual taken target, as a word address.
- upd_pred_taken, in, 1: pred_taken that was carried down the pipe with this branch.
- upd_count, out, COUNT_W: number of upd_en cycles.
- mispredict_count, out, COUNT_W: number of upd_en cycles with upd_pred_taken != upd_taken.

## Operation
Entry fields and address split:
- Each entry: valid, tag = pc[31:INDEX_W+2], target[29:0], ctr[CTR_W-1:0].
- One LRU bit per set when WAYS=2; it names the way to evict next.

Lookup (combinational, no internal register on the path):
- hit = OR over ways of (valid & tag match).
- Only one way can match at a time; allocation guarantees this.
- On miss: pred_taken=0 and pred_target=0.

Update (when upd_en and not flush), applied at the clock edge:
- Matching way found:
  - Taken: ctr saturating-increments and target is overwritten with upd_target.
  - Not taken: ctr saturating-decrements; target is left unchanged.
  - The matched way becomes MRU (LRU points to the other way).
  - The entry stays valid even when ctr reaches 0.
- No match and upd_taken:
  - Allocate the lowest-numbered invalid way; if all ways are valid, allocate the LRU way.
  - Write valid=1, the tag, target=upd_target, ctr = 2**(CTR_W-1) (weakly taken).
  - The allocated way becomes MRU.
- No match and not taken: no allocation and no state change.
- WAYS=1: there is no LRU state; a taken miss always replaces way 0.

Flush:
- Clears every valid bit and every LRU bit next edge.
- Takes priority over a simultaneous upd_en: that update is dropped from the table but still counted by the performance counters.

Performance counters:
- upd_count increments on every upd_en.
- mispredict_count increments when upd_en & (upd_pred_taken != upd_taken).
- Both wrap modulo 2**COUNT_W.
- flush does not clear them.

## Timing
- Lookup latency is 0 cycles: hit, pred_taken and pred_target are combinational from lookup_pc and registered state.
- An update is visible to lookups from the cycle after the edge that samples upd_en.
- Same-cycle lookup and update to the same set: the lookup sees the pre-update state. There is no bypass.
- Reset (asynchronous, takes effect immediately, including mid-update): all valid bits, LRU bits, counters, targets and tags go to 0. Reset values of the outputs:
  - hit=0, pred_taken=0, pred_target=0
  - upd_count=0, mispredict_count=0
- Saturation: ctr never wraps; it stays at 2**CTR_W-1 on taken and at 0 on not-taken.

## Test plan
All scenarios use INDEX_W=2, WAYS=2, CTR_W=2 unless stated.
- Reset: assert nRST=0 mid-cycle, lookup_pc=0x40 -> hit=0, pred_taken=0, pred_target=0, both counters 0, immediately and without waiting for a clock edge.
- Allocate and hit: upd_en with upd_pc=0x40, taken, upd_target=0x40 -> next cycle lookup 0x40 gives hit=1, pred_taken=1, pred_target=0x40.
- Counter saturation, continuing from the previous scenario (ctr=2):
  - Three not-taken updates: ctr goes 1, 0, 0; pred_taken=0 after the first; hit stays 1.
  - Then four taken updates: ctr goes 1, 2, 3, 3; pred_taken=1 from the second.
- LRU eviction:
  - Sequence: taken updates to 0x40, then 0x80 (set 0, ways 0 and 1), then 0x40 again, then 0xC0.
  - Result: 0x80 is evicted (lookup 0x80 gives hit=0); 0x40 and 0xC0 hit. A not-taken update to 0x100 allocates nothing.
- Flush:
  - flush together with a taken upd_en to 0x40 -> all lookups miss next cycle; upd_count still increments.
  - Same-cycle update plus lookup to the same set -> the lookup returns the old value.
- Counters: COUNT_W=4; issue 17 updates, 3 of them with upd_pred_taken != upd_taken -> upd_count=1 (wrapped), mispredict_count=3.
